// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RISC-V immediate generator. Classifies the
//                immediate format of one instruction per cycle and emits the
//                extended immediate through a 2-entry elastic buffer
//                (main register plus skid register).
//                Optional feature macro: IMM_ZICSR_EN (CSR immediate, fmt Z).
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;
`ifdef IMM_ZICSR_EN
    localparam logic [2:0] c_FMT_Z    = 3'd6;
`endif

    localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] c_OP_JALR    = 7'b1100111;
    localparam logic [6:0] c_OP_STORE   = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OP_LUI     = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;
    localparam logic [6:0] c_OP_OP      = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE   = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] c_OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] c_OP_OP32    = 7'b0111011;

    logic [6:0]       w_opcode;
    logic [31:0]      w_imm32;
    logic [2:0]       w_fmt;
    logic             w_illegal;
    logic [XLEN-1:0]  w_imm;
    logic             w_in_fire;
    logic             w_out_fire;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic             r_main_ill;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_ill;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_opcode = in_inst[6:0];

    // Format classification and 32-bit immediate assembly; bit 31 of every
    // signed format is inst[31], so widening below only replicates bit 31.
    // Every listed opcode ends in 2'b11, so a bad low pair falls to default.
    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = c_FMT_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_LOAD, c_OP_OPIMM, c_OP_JALR: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_fmt   = c_FMT_I;
            end
            c_OP_STORE: begin
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_fmt   = c_FMT_S;
            end
            c_OP_BRANCH: begin
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
                w_fmt   = c_FMT_B;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm32 = {in_inst[31:12], 12'd0};
                w_fmt   = c_FMT_U;
            end
            c_OP_JAL: begin
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
                w_fmt   = c_FMT_J;
            end
            c_OP_OP, c_OP_FENCE: begin
                w_fmt = c_FMT_NONE;
            end
            c_OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                // CSR*I forms carry a 5-bit unsigned immediate in rs1 field
                if (in_inst[14]) begin
                    w_imm32 = {27'd0, in_inst[19:15]};
                    w_fmt   = c_FMT_Z;
                end
`endif
            end
            c_OP_OPIMM32: begin
                if (XLEN == 64) begin
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    w_fmt   = c_FMT_I;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_OP32: begin
                if (XLEN != 64) begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    // in_ready is the inverted skid flag, so it is a pure register output
    assign in_ready   = !r_skid_valid;
    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_fire = r_main_valid && out_ready;

    // Elastic buffer: main drives the outputs, skid absorbs one stalled input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= c_FMT_NONE;
            r_main_ill   <= 1'b0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= c_FMT_NONE;
            r_skid_ill   <= 1'b0;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                // Skid is older than anything arriving, promote it first
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_main_ill   <= r_skid_ill;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_imm   <= w_imm;
                r_main_fmt   <= w_fmt;
                r_main_ill   <= w_illegal;
                r_main_tag   <= in_tag;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_imm   <= w_imm;
                r_main_fmt   <= w_fmt;
                r_main_ill   <= w_illegal;
                r_main_tag   <= in_tag;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_fmt   <= w_fmt;
                r_skid_ill   <= w_illegal;
                r_skid_tag   <= in_tag;
            end
        end
    end

    assign out_valid   = r_main_valid;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_fmt;
    assign out_illegal = r_main_ill;
    assign out_tag     = r_main_tag;

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Classifies the immediate format and produces the sign- or zero-extended immediate at XLEN width. Results pass through a 2-entry elastic output buffer, so decode back-pressure never drops or reorders instructions. Adds U-type shifting, AUIPC, RV64 OP-IMM-32, an illegal-opcode flag and a side-band tag.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64 only.
TAG_W, 8, width of the opaque side-band tag (PC index/ROB id) carried alongside each instruction.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all buffered entries
in_valid  in  1  instruction valid
in_ready  out  1  block can accept this cycle
in_inst  in  32  instruction word
in_tag  in  TAG_W  side-band tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_imm  out  XLEN  extended immediate
out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
out_illegal  out  1  unsupported opcode or inst[1:0] != 2'b11
out_tag  out  TAG_W  tag of the current result

Behaviour:
- Decode is combinational on in_inst. The result is registered, giving 1-cycle latency from an accepted input to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Opcode map:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 → I: sext(inst[31:20]).
  - STORE 0100011 → S: sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011 → B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - LUI 0110111, AUIPC 0010111 → U: sext({inst[31:12], 12'b0}).
  - JAL 1101111 → J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - OP 0110011, FENCE 0001111, SYSTEM 1110011 → NONE, imm 0, legal.
  - OP-IMM-32 0011011 and OP-32 0111011: handled as I and NONE respectively when XLEN=64; illegal when XLEN=32.
  - Any other opcode → NONE, imm 0, illegal=1.
- Sign extension always replicates inst[31] up to bit XLEN-1.
- Buffer is a main register plus a skid register:
  - in_ready = !skid_full, registered; it does not depend combinationally on out_ready.
  - Transfer occurs when valid&&ready on either side.
  - Main empty or draining this cycle → input loads main.
  - Main full and stalled → input loads skid. in_ready falls the next cycle.
  - Main drains while skid is full → skid moves to main, skid empties, and in_ready rises the next cycle.
  - Ordering is strictly FIFO; accept and drain in the same cycle is legal at any occupancy.
- Outputs are held stable while out_valid && !out_ready.
- flush: takes priority over the same-cycle input. Next cycle out_valid=0 and in_ready=1; an input presented in the flush cycle is discarded.
- Reset (async assert, synchronous deassert expected from the system):
  - Cleared to 0: out_valid, out_imm, out_fmt, out_illegal, out_tag.
  - in_ready=1.
  - Any in-flight entries are lost.

Optional Feature:
IMM_ZICSR_EN
- Defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z, imm = zero-extended inst[19:15]. Other SYSTEM encodings stay NONE.
- Undefined: all SYSTEM encodings → NONE, imm 0, legal; fmt code 6 is never produced.

Test Plan:
- XLEN=32, LUI 0x12345037 with out_ready=1 → next cycle out_valid=1, out_imm=0x12345000, fmt=4, illegal=0.
- XLEN=32, BEQ 0xFE000EE3 then JAL 0x0000006F back-to-back → imm 0xFFFFFFFC fmt 3, then imm 0 fmt 5, on consecutive cycles.
- Continuous input with tags 1,2,3,4 and out_ready=0 for 3 cycles:
  - tags 1,2 accepted; in_ready=0 from the cycle after tag 2 is accepted.
  - out_ready then raised → tags 1,2,3,4 emerge in order, with no loss or duplicate.
- Both entries full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed tags are never output.
- XLEN=64, ADDI 0xFFF00093 → 0xFFFFFFFFFFFFFFFF fmt 1; instruction 0x00000000 → illegal=1, fmt 0, imm 0.
- rst_n pulsed low mid-stream with the buffer full → all outputs 0 and in_ready=1 asynchronously; the first post-reset input appears with 1-cycle latency.
